// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM encoding, owner codes and
// the default starvation limit.
package dmem_arb_pkg;

    localparam int STARVE_MAX_DEF = 4;

    typedef enum logic {
        CPU_PRI   = 1'b0,
        DMA_FORCE = 1'b1
    } arb_state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DMA  = 2'd2
    } owner_e;

endpackage

// File: rtl/arb_starve_cnt.sv
// Counts consecutive denied DMA-request cycles; sat flags the cycle in which
// the count would reach STARVE_MAX, and the counter wraps to zero there.
module arb_starve_cnt #(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output logic sat
);
    localparam int CW = $clog2(STARVE_MAX + 1);

    logic [CW-1:0] cnt;

    assign sat = inc && (cnt == CW'(STARVE_MAX - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cnt <= '0;
        else if (clr || sat)
            cnt <= '0;
        else if (inc)
            cnt <= cnt + CW'(1);
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter: CPU has priority, a starvation counter
// forces a one-cycle DMA slot by stalling the CPU. DMA read data is registered.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    arb_state_e state_q, state_d;
    owner_e     owner;
    logic       gnt_raw, stall_raw, we_sel;
    logic       cnt_inc, cnt_clr, cnt_sat;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state_q <= CPU_PRI;
        else
            state_q <= state_d;
    end

    always_comb begin
        owner     = OWN_NONE;
        gnt_raw   = 1'b0;
        stall_raw = 1'b0;
        case (state_q)
            CPU_PRI: begin
                if (cpu_req) begin
                    owner = OWN_CPU;
                end else if (dma_req) begin
                    owner   = OWN_DMA;
                    gnt_raw = 1'b1;
                end
            end
            DMA_FORCE: begin
                // Forced slot only stalls the CPU if there is still a DMA request to serve.
                if (dma_req) begin
                    owner     = OWN_DMA;
                    gnt_raw   = 1'b1;
                    stall_raw = cpu_req;
                end else if (cpu_req) begin
                    owner = OWN_CPU;
                end
            end
            default: owner = OWN_NONE;
        endcase
    end

    assign cnt_inc = (state_q == CPU_PRI) && dma_req && !gnt_raw;
    assign cnt_clr = (state_q == DMA_FORCE) || !dma_req || gnt_raw;

    arb_starve_cnt #(.STARVE_MAX(STARVE_MAX)) u_starve (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .sat   (cnt_sat)
    );

    always_comb begin
        state_d = CPU_PRI;
        if (state_q == CPU_PRI && cnt_sat)
            state_d = DMA_FORCE;
    end

    always_comb begin
        we_sel    = 1'b0;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        case (owner)
            OWN_CPU: we_sel = cpu_we;
            OWN_DMA: begin
                we_sel    = dma_we;
                mem_addr  = dma_addr;
                mem_wdata = dma_wdata;
            end
            default: we_sel = 1'b0;
        endcase
    end

    // Nothing is granted or written while reset is held low.
    assign mem_we    = we_sel && reset;
    assign dma_gnt   = gnt_raw && reset;
    assign cpu_stall = stall_raw;
    assign cpu_rdata = mem_rdata;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dma_rvalid <= 1'b0;
            dma_rdata  <= '0;
        end else begin
            dma_rvalid <= dma_gnt && !dma_we;
            if (dma_gnt && !dma_we)
                dma_rdata <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: per-cycle expectations and expected DMA read
// data are queued by the stimulus and consumed by an independent monitor.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, dma_req, dma_we;
    logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
    logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        cpu_stall, dma_gnt, dma_rvalid, mem_we;

    logic [31:0] mem [0:255];

    typedef struct {
        logic        gnt, st, we, rv, ck;
        logic [31:0] rd;
        string       nm;
    } exp_t;

    exp_t        eq[$];
    logic [31:0] rq[$];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Behavioural single-port memory: combinational read, write on rising edge.
    assign mem_rdata = mem[mem_addr[9:2]];
    always @(posedge clk) if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One cycle of stimulus plus the expected combinational/registered outputs.
    task automatic cyc(input logic rs, input logic cr, input logic cw, input logic [31:0] ca,
                       input logic [31:0] cd, input logic dr, input logic dw,
                       input logic [31:0] da, input logic [31:0] dd,
                       input logic e_gnt, input logic e_st, input logic e_we, input logic e_rv,
                       input logic ck, input logic [31:0] e_rd, input string nm);
        exp_t e;
        @(negedge clk);
        reset = rs;
        cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
        dma_req = dr; dma_we = dw; dma_addr = da; dma_wdata = dd;
        e.gnt = e_gnt; e.st = e_st; e.we = e_we; e.rv = e_rv; e.ck = ck; e.rd = e_rd; e.nm = nm;
        eq.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (eq.size() > 0) begin
                e = eq.pop_front();
                chk({e.nm, ".gnt"},   {31'd0, dma_gnt},    {31'd0, e.gnt});
                chk({e.nm, ".stall"}, {31'd0, cpu_stall},  {31'd0, e.st});
                chk({e.nm, ".we"},    {31'd0, mem_we},     {31'd0, e.we});
                chk({e.nm, ".rvalid"},{31'd0, dma_rvalid}, {31'd0, e.rv});
                if (e.ck) chk({e.nm, ".cpu_rdata"}, cpu_rdata, e.rd);
            end
            if (reset && dma_rvalid) begin
                if (rq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL dma_rdata: got rvalid with %h, expected none", dma_rdata);
                end else begin
                    chk("dma_rdata", dma_rdata, rq.pop_front());
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL timeout: got no finish, expected finish before 100000");
        $fatal(1, "timeout");
    end

    initial begin : stim
        for (int i = 0; i < 256; i++) mem[i] = '0;
        reset = 1'b0;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst.rvalid", {31'd0, dma_rvalid}, 32'd0);
        chk("rst.rdata",  dma_rdata, 32'd0);
        chk("rst.gnt",    {31'd0, dma_gnt}, 32'd0);

        // CPU store/load with DMA idle
        cyc(1, 1,1,32'h10,32'h1234, 0,0,0,0,            0,0,1,0, 0,0,        "cpu_st");
        cyc(1, 1,0,32'h10,0,        0,0,0,0,            0,0,0,0, 1,32'h1234, "cpu_ld");
        cyc(1, 0,0,32'h10,0,        0,0,0,0,            0,0,0,0, 1,32'h1234, "idle");

        // DMA write then back-to-back read with the CPU idle
        cyc(1, 0,0,0,0,             1,1,32'h20,32'hCAFE, 1,0,1,0, 0,0,       "dma_wr");
        cyc(1, 0,0,0,0,             1,0,32'h20,0,        1,0,0,0, 0,0,       "dma_rd");
        rq.push_back(32'hCAFE);
        cyc(1, 0,0,0,0,             0,0,0,0,             0,0,0,1, 0,0,       "dma_rv");
        cyc(1, 0,0,0,0,             0,0,0,0,             0,0,0,0, 0,0,       "dma_rv_end");

        // Continuous CPU traffic: four denied cycles then a forced slot
        for (int i = 0; i < 4; i++)
            cyc(1, 1,0,32'h10,0,    1,0,32'h20,0,        0,0,0,0, 1,32'h1234, "starve_deny");
        cyc(1, 1,0,32'h10,0,        1,0,32'h20,0,        1,1,0,0, 1,32'hCAFE, "force_rd");
        rq.push_back(32'hCAFE);
        cyc(1, 1,0,32'h10,0,        0,0,0,0,             0,0,0,1, 1,32'h1234, "force_resume");

        // Dropping dma_req clears the count; the forced slot is measured from the re-raise
        cyc(1, 1,0,32'h10,0,        1,1,32'h30,32'hBEEF, 0,0,0,0, 0,0,       "pre_drop0");
        cyc(1, 1,0,32'h10,0,        1,1,32'h30,32'hBEEF, 0,0,0,0, 0,0,       "pre_drop1");
        cyc(1, 1,0,32'h10,0,        0,0,0,0,             0,0,0,0, 0,0,       "drop");
        for (int i = 0; i < 4; i++)
            cyc(1, 1,0,32'h10,0,    1,1,32'h30,32'hBEEF, 0,0,0,0, 0,0,       "reraise_deny");
        cyc(1, 1,0,32'h10,0,        1,1,32'h30,32'hBEEF, 1,1,1,0, 0,0,       "force_wr");
        cyc(1, 1,0,32'h30,0,        0,0,0,0,             0,0,0,0, 1,32'hBEEF, "chk_force_wr");

        // Grant in CPU_PRI on the would-saturate cycle wins and keeps CPU_PRI
        for (int i = 0; i < 3; i++)
            cyc(1, 1,0,32'h10,0,    1,1,32'h40,32'h5,    0,0,0,0, 0,0,       "sat_deny");
        cyc(1, 0,0,32'h10,0,        1,1,32'h40,32'h5,    1,0,1,0, 0,0,       "sat_gnt");
        cyc(1, 1,0,32'h40,0,        1,1,32'h44,32'h6,    0,0,0,0, 1,32'h5,   "sat_no_force");
        cyc(1, 0,0,0,0,             0,0,0,0,             0,0,0,0, 0,0,       "sat_idle");

        // Reset in the cycle after a granted read drops rvalid and blocks writes
        cyc(1, 0,0,0,0,             1,0,32'h10,0,        1,0,0,0, 0,0,       "pre_rst_rd");
        cyc(0, 1,1,32'h50,32'hDEAD, 0,0,0,0,             0,0,0,0, 0,0,       "rst_low0");
        #1;
        chk("rst_mid.rvalid", {31'd0, dma_rvalid}, 32'd0);
        chk("rst_mid.rdata",  dma_rdata, 32'd0);
        cyc(0, 1,1,32'h50,32'hDEAD, 0,0,0,0,             0,0,0,0, 0,0,       "rst_low1");
        cyc(1, 1,0,32'h50,0,        1,0,32'h20,0,        0,0,0,0, 1,32'h0,   "post_rst");
        cyc(1, 0,0,0,0,             1,0,32'h20,0,        1,0,0,0, 0,0,       "post_rst_rd");
        rq.push_back(32'hCAFE);
        cyc(1, 0,0,0,0,             0,0,0,0,             0,0,0,1, 0,0,       "post_rst_rv");
        cyc(1, 0,0,0,0,             0,0,0,0,             0,0,0,0, 0,0,       "end_idle");

        repeat (3) @(negedge clk);
        #3;
        chk("eq_drained", eq.size(), 32'd0);
        chk("rq_drained", rq.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
